// File: rtl/bin_to_bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t ADD3_THRESH = 4'd5;
  localparam bcd_digit_t ADD3_VAL    = 4'd3;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction for one BCD digit: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next decade.
module bcd_add3_digit
  import bin_to_bcd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  bcd_digit_t w_digit;

  assign w_digit = i_digit;
  assign o_digit = (w_digit >= ADD3_THRESH) ? (w_digit + ADD3_VAL) : w_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one bit per cycle, saturating to all-9s.
// Optional leading-zero blanking is enabled with the LEADING_ZERO_BLANK_EN macro.
module bin_to_bcd_seq
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf,
  output logic [DIGITS-1:0]     blank
);

  localparam int                  CNT_W      = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0]    MAX_BIN    = BIN_W'(10**DIGITS - 1);
  localparam logic [CNT_W-1:0]    LAST_SHIFT = CNT_W'(BIN_W - 1);
  localparam logic [4*DIGITS-1:0] ALL_NINES  = {DIGITS{4'h9}};

  state_t                r_state;
  state_t                w_next;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_finish;

  logic [BIN_W-1:0]      r_shreg;
  logic [4*DIGITS-1:0]   r_scratch;
  logic [4*DIGITS-1:0]   w_adj;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_ovf_n;

  logic                  r_done;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  r_ovf;
  logic [DIGITS-1:0]     r_blank;
  logic [DIGITS-1:0]     w_blank;

  for (genvar k = 0; k < DIGITS; k++) begin : g_add3
    bcd_add3_digit u_add3 (
      .i_digit (r_scratch[4*k +: 4]),
      .o_digit (w_adj[4*k +: 4])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = SHIFT;
        end
      end
      SHIFT: begin
        w_shift = 1'b1;
        if (r_cnt == LAST_SHIFT) w_next = DONE;
      end
      DONE: begin
        w_finish = 1'b1;
        w_next   = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic w_seen;

  // Walk from the MSD down; digit 0 is never blanked so zero still shows "0".
  always_comb begin
    w_blank = '0;
    w_seen  = 1'b0;
    if (!r_ovf_n) begin
      for (int k = DIGITS - 1; k >= 1; k--) begin
        if (r_scratch[4*k +: 4] != 4'd0) w_seen = 1'b1;
        w_blank[k] = !w_seen;
      end
    end
  end
`else
  assign w_blank = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_ovf_n   <= 1'b0;
      r_done    <= 1'b0;
      r_bcd     <= '0;
      r_ovf     <= 1'b0;
      r_blank   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_shreg   <= bin;
        r_scratch <= '0;
        r_cnt     <= '0;
        r_ovf_n   <= (bin > MAX_BIN);
      end
      // Bits leaving the top digit only matter on overflow, where the result is replaced.
      if (w_shift) begin
        {r_scratch, r_shreg} <= {w_adj, r_shreg} << 1;
        r_cnt                <= r_cnt + 1'b1;
      end
      if (w_finish) begin
        r_bcd   <= r_ovf_n ? ALL_NINES : r_scratch;
        r_ovf   <= r_ovf_n;
        r_blank <= w_blank;
        r_done  <= 1'b1;
      end
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = r_done;
  assign bcd   = r_bcd;
  assign ovf   = r_ovf;
  assign blank = r_blank;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4).
// Blank expectations follow LEADING_ZERO_BLANK_EN.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;
  logic [3:0]  blank;

  int checks = 0;
  int errors = 0;
  int latency, busyCnt, doneCnt;
  int firstDone, secondDone, doneSeen;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf),
    .blank (blank)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] expBlank(input logic [3:0] enabledValue);
`ifdef LEADING_ZERO_BLANK_EN
    return enabledValue;
`else
    return 4'b0000;
`endif
  endfunction

  // Sample i is taken 1ns after edge E+i, where E is the accepting edge.
  task automatic applyStimulus(input logic [13:0] value, input int extraA, input int extraB,
                               output int lat, output int nBusy, output int nDone);
    start = 1'b1;
    bin   = value;
    tick();
    start = 1'b0;
    bin   = value ^ 14'h2AAA;
    lat   = -1;
    nBusy = 0;
    nDone = 0;
    for (int i = 0; i < 20; i++) begin
      if (busy) nBusy++;
      if (done) begin
        nDone++;
        if (lat < 0) lat = i;
      end
      start = (i == extraA) || (i == extraB);
      tick();
    end
    start = 1'b0;
  endtask

  task automatic convertAndCheck(input string tag, input logic [13:0] value,
                                 input logic [15:0] expBcd, input logic expOvf, input logic [3:0] expBl);
    int lat, nb, nd;
    applyStimulus(value, -1, -1, lat, nb, nd);
    checkOutput({tag, "_done"}, nd, 1);
    checkOutput({tag, "_bcd"}, bcd, expBcd);
    checkOutput({tag, "_ovf"}, ovf, expOvf);
    checkOutput({tag, "_blank"}, blank, expBl);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bin   = '0;
    tick();
    tick();
    rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_bcd", bcd, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_blank", blank, 0);

    $display("[TB] test 1: 1234 latency and handshake");
    applyStimulus(14'd1234, -1, -1, latency, busyCnt, doneCnt);
    checkOutput("t1_latency", latency, 15);
    checkOutput("t1_busy_cycles", busyCnt, 15);
    checkOutput("t1_done_count", doneCnt, 1);
    checkOutput("t1_bcd", bcd, 16'h1234);
    checkOutput("t1_ovf", ovf, 0);
    checkOutput("t1_blank", blank, 4'b0000);

    $display("[TB] test 2/3: boundaries");
    convertAndCheck("t2_zero", 14'd0, 16'h0000, 1'b0, expBlank(4'b1110));
    convertAndCheck("t2_9999", 14'd9999, 16'h9999, 1'b0, 4'b0000);
    convertAndCheck("t3_10000", 14'd10000, 16'h9999, 1'b1, 4'b0000);
    convertAndCheck("t3_16383", 14'd16383, 16'h9999, 1'b1, 4'b0000);

    $display("[TB] test 4: start while busy ignored");
    applyStimulus(14'd567, 3, 7, latency, busyCnt, doneCnt);
    checkOutput("t4_done_count", doneCnt, 1);
    checkOutput("t4_latency", latency, 15);
    checkOutput("t4_bcd", bcd, 16'h0567);
    checkOutput("t4_blank", blank, expBlank(4'b1000));

    // Held start: the IDLE cycle carrying done accepts the next conversion.
    start      = 1'b1;
    bin        = 14'd321;
    firstDone  = -1;
    secondDone = -1;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        if (firstDone < 0) firstDone = i;
        else if (secondDone < 0) secondDone = i;
      end
      tick();
    end
    start = 1'b0;
    checkOutput("t4_b2b_first", firstDone, 15);
    checkOutput("t4_b2b_second", secondDone, 31);
    checkOutput("t4_b2b_bcd", bcd, 16'h0321);

    $display("[TB] test 5: reset mid-conversion");
    start = 1'b1;
    bin   = 14'd4321;
    tick();
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_bcd", bcd, 0);
    checkOutput("t5_done", done, 0);
    checkOutput("t5_ovf", ovf, 0);
    doneSeen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) doneSeen++;
      tick();
    end
    checkOutput("t5_no_done", doneSeen, 0);
    convertAndCheck("t5_4321", 14'd4321, 16'h4321, 1'b0, 4'b0000);

    $display("[TB] test 6: leading-zero blanking");
    convertAndCheck("t6_42", 14'd42, 16'h0042, 1'b0, expBlank(4'b1100));
    convertAndCheck("t6_0", 14'd0, 16'h0000, 1'b0, expBlank(4'b1110));
    convertAndCheck("t6_7000", 14'd7000, 16'h7000, 1'b0, 4'b0000);
    convertAndCheck("t6_12000", 14'd12000, 16'h9999, 1'b1, 4'b0000);

    // Outputs must hold between conversions.
    for (int i = 0; i < 5; i++) tick();
    checkOutput("hold_bcd", bcd, 16'h9999);
    checkOutput("hold_ovf", ovf, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
